layer_tmux: RTL
===============

Name: layer_tmux

Overview:
- Fully-connected NN layer, next generation of the per-node-parallel layer.
- Time-multiplexes NODE_NUM neurons over LANES physical MAC lanes, with bias, selectable activation (ReLU/linear), and fixed-point rescale with saturation.
- Weights are runtime-loadable.
- Upstream and downstream connect through valid/ready handshakes; the block sits between quantized autoencoder layers.

Parameters:
- NODE_NUM, 16, neurons in layer; must be a multiple of LANES.
- INPUT_NUM, 8, inputs per neuron.
- LANES, 4, parallel MAC lanes.
- IN_WIDTH, 16, signed input width.
- IN_FRACTION, 14, input fraction bits.
- W_WIDTH, 8, signed weight/bias width.
- W_FRACTION, 7, weight fraction bits.
- OUTPUT_WIDTH, 16, signed output width.
- OUTPUT_FRACTION, 14, output fraction bits; must be <= IN_FRACTION+W_FRACTION.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input.
- x  in  IN_WIDTH*INPUT_NUM  input k at x[k*IN_WIDTH +: IN_WIDTH].
- act_mode  in  1  0=ReLU, 1=linear; sampled with input.
- w_we  in  1  weight write enable.
- w_addr  in  $clog2(NODE_NUM*(INPUT_NUM+1))  weight address = n*(INPUT_NUM+1)+k; k=INPUT_NUM selects the bias.
- w_data  in  W_WIDTH  signed weight/bias.
- out  out  OUTPUT_WIDTH*NODE_NUM  node n at out[n*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- out_valid  out  1  out holds a complete result.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Derived constants:
  - ACC_W = IN_WIDTH+W_WIDTH+$clog2(INPUT_NUM+1).
  - GROUPS = NODE_NUM/LANES.
  - SHIFT = IN_FRACTION+W_FRACTION-OUTPUT_FRACTION.
- Reset values:
  - FSM = IDLE; out = 0; out_valid = 0; all counters and accumulators = 0.
  - in_ready = 0 while rst is high.
  - Weight storage is not reset; it retains its contents.
- FSM states: IDLE, MAC, FIN, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch x and act_mode, set group g=0 and term k=0, clear accumulators, go to MAC.
- MAC, one term per cycle for k=0..INPUT_NUM:
  - Lane l accumulates x[k]*W[(g*LANES+l)*(INPUT_NUM+1)+k] for k<INPUT_NUM.
  - At k=INPUT_NUM it adds the bias sign-extended and shifted left by IN_FRACTION.
  - After k=INPUT_NUM, go to FIN.
- FIN, one cycle:
  - For each lane, apply ReLU if act_mode=0 (negative -> 0).
  - Arithmetic shift right by SHIFT (floor).
  - Saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - Write the result to out node g*LANES+l.
  - If g<GROUPS-1: g++, k=0, clear accumulators, go to MAC. Otherwise go to OUT.
- Latency: out_valid rises exactly GROUPS*(INPUT_NUM+2) clocks after the accepting edge.
- OUT:
  - out_valid = 1; out is held stable until the out handshake.
  - in_ready = out_ready, which allows back-to-back operation.
  - out_ready=1 with in_valid=1: both handshakes complete, new input is latched, go to MAC, out_valid drops next cycle.
  - out_ready=1 with in_valid=0: go to IDLE.
- Weight writes:
  - Take effect only in IDLE.
  - Ignored in MAC/FIN/OUT, so they cannot corrupt an in-flight computation.
  - Addresses >= NODE_NUM*(INPUT_NUM+1) are ignored.
- Reset mid-operation: abort, clear out and out_valid; in_ready = 1 on the first cycle after rst deasserts.
- No overflow inside the accumulator: ACC_W is sized for the worst case.

Decomposition:
- Package layer_pkg holds:
  - state enum (IDLE, MAC, FIN, OUT);
  - function acc_width(in_w, w_w, n);
  - function sat_shift(acc, shift, out_w), which performs floor shift plus signed saturation.
- Sub-module mac_lane: one signed multiplier plus ACC_W accumulator with clear, enable and bias-add select. Instantiated LANES times.

Test Plan:
All scenarios use NODE_NUM=4, INPUT_NUM=2, LANES=2, other parameters at default; latency = 8 cycles.
- Scenario 1: all weights 0x40 (0.5), biases 0, x={0x2000,0x1000}, ReLU -> every node 0x1800, out_valid exactly 8 cycles after accept.
- Scenario 2: weights 0x80 (-1), bias 0, x={0x2000,0x2000} -> ReLU: all 0x0000; linear: all 0xC000.
- Scenario 3: x={0x7FFF,0x7FFF}, weights/bias 0x7F, linear -> 0x7FFF. Same with 0x80 -> 0x8000 (both saturate).
- Scenario 4: hold out_ready=0 for 10 cycles with in_valid=1 -> out stable, in_ready=0, no accept. Then out_ready=1 with in_valid=1 -> both handshakes in the same cycle; next out_valid 8 cycles later.
- Scenario 5: assert rst on MAC cycle 3 -> out=0, out_valid=0, in_ready=1 one cycle after release. Rerunning scenario 1 gives 0x1800 (weights retained).
- Scenario 6: w_we to node 0, k=0 with 0x00 during MAC -> ignored; result still 0x1800. The same write in IDLE makes node 0 = 0x0800.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed fully-connected layer.
package layer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StFin,
        StOut
    } state_e;

    // Working width for the rescale helper; wide enough for any practical accumulator.
    localparam int unsigned SatW = 64;

    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned w_w,
                                              input int unsigned n);
        return in_w + w_w + $clog2(n + 1);
    endfunction

    // Floor shift followed by saturation into a signed out_w-bit range.
    function automatic logic signed [SatW-1:0] sat_shift(input logic signed [SatW-1:0] acc,
                                                         input int unsigned shift,
                                                         input int unsigned out_w);
        logic signed [SatW-1:0] s;
        logic signed [SatW-1:0] hi;
        logic signed [SatW-1:0] lo;
        s  = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One physical MAC lane: signed multiply-accumulate with clear, enable and bias-add select.
module mac_lane #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned W_WIDTH     = 8,
    parameter int unsigned IN_FRACTION = 14,
    parameter int unsigned ACC_W       = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    bias_i,
    input  logic signed [IN_WIDTH-1:0] x_i,
    input  logic signed [W_WIDTH-1:0]  w_i,
    output logic signed [ACC_W-1:0]    acc_o
);

    logic signed [IN_WIDTH+W_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]            term;
    logic signed [ACC_W-1:0]            acc_d;
    logic signed [ACC_W-1:0]            acc_q;

    always_comb begin
        prod  = x_i * w_i;
        // Bias is aligned to the product's binary point before it is added.
        term  = bias_i ? (ACC_W'(w_i) <<< IN_FRACTION) : ACC_W'(prod);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/layer_tmux.sv
// Fully-connected layer that time-multiplexes NODE_NUM neurons over LANES MAC lanes,
// with runtime-loadable weights, bias, ReLU/linear activation and saturating rescale.
module layer_tmux
    import layer_pkg::*;
#(
    parameter int unsigned NODE_NUM        = 16,
    parameter int unsigned INPUT_NUM       = 8,
    parameter int unsigned LANES           = 4,
    parameter int unsigned IN_WIDTH        = 16,
    parameter int unsigned IN_FRACTION     = 14,
    parameter int unsigned W_WIDTH         = 8,
    parameter int unsigned W_FRACTION      = 7,
    parameter int unsigned OUTPUT_WIDTH    = 16,
    parameter int unsigned OUTPUT_FRACTION = 14
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [IN_WIDTH*INPUT_NUM-1:0]               x,
    input  logic                                        act_mode,
    input  logic                                        w_we,
    input  logic [$clog2(NODE_NUM*(INPUT_NUM+1))-1:0]   w_addr,
    input  logic [W_WIDTH-1:0]                          w_data,
    output logic [OUTPUT_WIDTH*NODE_NUM-1:0]            out,
    output logic                                        out_valid,
    input  logic                                        out_ready
);

    localparam int unsigned ACC_W  = acc_width(IN_WIDTH, W_WIDTH, INPUT_NUM);
    localparam int unsigned GROUPS = NODE_NUM / LANES;
    localparam int unsigned SHIFT  = IN_FRACTION + W_FRACTION - OUTPUT_FRACTION;
    localparam int unsigned DEPTH  = NODE_NUM * (INPUT_NUM + 1);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned KW     = $clog2(INPUT_NUM + 1);
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [KW-1:0] KLast = KW'(INPUT_NUM);
    localparam logic [GW-1:0] GLast = GW'(GROUPS - 1);

    state_e                            state_q, state_d;
    logic [GW-1:0]                     g_q, g_d;
    logic [KW-1:0]                     k_q, k_d;
    logic [IN_WIDTH*INPUT_NUM-1:0]     x_q, x_d;
    logic                              act_q, act_d;
    logic [OUTPUT_WIDTH*NODE_NUM-1:0]  out_q, out_d;

    logic                              accept;
    logic                              lane_clr;
    logic                              lane_en;
    logic                              lane_bias;
    logic signed [IN_WIDTH-1:0]        lane_x;
    logic signed [W_WIDTH-1:0]         lane_w   [LANES];
    logic signed [ACC_W-1:0]           lane_acc [LANES];
    logic [AW-1:0]                     rd_addr;
    int                                kx;
    logic signed [SatW-1:0]            sat_in;
    logic [OUTPUT_WIDTH-1:0]           sat_out;

    logic signed [W_WIDTH-1:0]         w_mem [DEPTH];

    assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StOut) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = (state_q == StOut);

    // Writes are gated to IDLE so an in-flight computation always sees one weight set.
    always_ff @(posedge clk) begin
        if (w_we && (state_q == StIdle) && (32'(w_addr) < DEPTH)) begin
            w_mem[w_addr] <= w_data;
        end
    end

    always_comb begin
        kx      = (k_q == KLast) ? 0 : int'(k_q);
        lane_x  = x_q[kx*int'(IN_WIDTH) +: IN_WIDTH];
        rd_addr = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            rd_addr   = AW'((int'(g_q) * int'(LANES) + l) * int'(INPUT_NUM + 1) + int'(k_q));
            lane_w[l] = w_mem[rd_addr];
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        k_d       = k_q;
        x_d       = x_q;
        act_d     = act_q;
        out_d     = out_q;
        lane_clr  = 1'b0;
        lane_en   = 1'b0;
        lane_bias = 1'b0;
        sat_in    = '0;
        sat_out   = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    x_d      = x;
                    act_d    = act_mode;
                    g_d      = '0;
                    k_d      = '0;
                    lane_clr = 1'b1;
                    state_d  = StMac;
                end
            end
            StMac: begin
                lane_en   = 1'b1;
                lane_bias = (k_q == KLast);
                if (k_q == KLast) begin
                    state_d = StFin;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StFin: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    sat_in = SatW'(lane_acc[l]);
                    if (!act_q && (sat_in < 0)) begin
                        sat_in = '0;
                    end
                    sat_out = OUTPUT_WIDTH'(sat_shift(sat_in, SHIFT, OUTPUT_WIDTH));
                    out_d[(int'(g_q) * int'(LANES) + l) * int'(OUTPUT_WIDTH) +: OUTPUT_WIDTH] =
                        sat_out;
                end
                if (g_q != GLast) begin
                    g_d      = g_q + 1'b1;
                    k_d      = '0;
                    lane_clr = 1'b1;
                    state_d  = StMac;
                end else begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (accept) begin
                        x_d      = x;
                        act_d    = act_mode;
                        g_d      = '0;
                        k_d      = '0;
                        lane_clr = 1'b1;
                        state_d  = StMac;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            g_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            act_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            k_q     <= k_d;
            x_q     <= x_d;
            act_q   <= act_d;
            out_q   <= out_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .IN_WIDTH    (IN_WIDTH),
            .W_WIDTH     (W_WIDTH),
            .IN_FRACTION (IN_FRACTION),
            .ACC_W       (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (lane_clr),
            .en_i   (lane_en),
            .bias_i (lane_bias),
            .x_i    (lane_x),
            .w_i    (lane_w[l]),
            .acc_o  (lane_acc[l])
        );
    end

endmodule
